io_switch_capture: RTL

//  Memory-mapped input peripheral for the data bus: the sequential read-side

---
 rtl/io_switch_capture.sv | 110 +++++++++++
 1 files changed

// File: rtl/io_switch_capture.sv
// Memory-mapped switch input port: synchronise, debounce, capture sticky edges
// into write-1-to-clear registers and raise a maskable level interrupt.
module io_switch_capture #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  sw,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              irq_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ADDR_STATE  = 2'd0;
    localparam logic [1:0] ADDR_RISE   = 2'd1;
    localparam logic [1:0] ADDR_FALL   = 2'd2;
    localparam logic [1:0] ADDR_IRQ_EN = 2'd3;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d, fall_q, fall_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] rise_clr, fall_clr, wdata;
    logic [1:0]       sel;
    logic             wr_en;
    logic             irq_d;
    logic             unused_bus_bits;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign sel   = addr_i[3:2];
    assign wr_en = enable_i & write_i;
    assign wdata = data_i[WIDTH-1:0];
    assign unused_bus_bits = ^{addr_i[31:4], addr_i[1:0], data_i};

    // Synchroniser chain for the asynchronous switch inputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= sw;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Per-bit debounce: accept a change after DEBOUNCE_CYCLES stable differing samples
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) stable_d[i] = sync[i];
                else                      cnt_d[i]    = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Sticky edge capture; a set on the same edge as a W1C clear wins
    always_comb begin
        rise_clr = (wr_en && sel == ADDR_RISE) ? wdata : '0;
        fall_clr = (wr_en && sel == ADDR_FALL) ? wdata : '0;
        rise_d   = (rise_q & ~rise_clr) | (stable_d & ~stable_q);
        fall_d   = (fall_q & ~fall_clr) | (~stable_d & stable_q);
        irq_en_d = (wr_en && sel == ADDR_IRQ_EN) ? wdata : irq_en_q;
        irq_d    = |((rise_d | fall_d) & irq_en_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            irq_en_q <= '0;
            irq_o    <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            irq_en_q <= irq_en_d;
            irq_o    <= irq_d;
        end
    end

    // Read mux, zero-extended and gated by the decoder select
    always_comb begin
        data_o = '0;
        if (enable_i) begin
            unique case (sel)
                ADDR_STATE:  data_o = 32'(stable_q);
                ADDR_RISE:   data_o = 32'(rise_q);
                ADDR_FALL:   data_o = 32'(fall_q);
                ADDR_IRQ_EN: data_o = 32'(irq_en_q);
                default:     data_o = '0;
            endcase
        end
    end

endmodule
